// File: rtl/mult_hilo_unit_if.sv
// EXE-stage command/operand bundle between the ID/EXE register and the HI/LO multiplier.
interface mult_hilo_unit_if #(
  parameter int WORD_LEN    = 32,
  parameter int EXE_CMD_LEN = 4
);
  logic                   valid;
  logic                   flush;
  logic [EXE_CMD_LEN-1:0] exe_cmd;
  logic [WORD_LEN-1:0]    op_a;
  logic [WORD_LEN-1:0]    op_b;
  logic [WORD_LEN-1:0]    result;
  logic                   stall;
  logic                   busy;
  logic [WORD_LEN-1:0]    hi;
  logic [WORD_LEN-1:0]    lo;

  modport master (
    output valid, flush, exe_cmd, op_a, op_b,
    input  result, stall, busy, hi, lo
  );

  modport slave (
    input  valid, flush, exe_cmd, op_a, op_b,
    output result, stall, busy, hi, lo
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// Multi-cycle signed shift-add multiplier with architectural HI/LO registers.
// MULT stalls the front end for WORD_LEN+1 cycles; MFHI/MFLO read HI/LO combinationally.
module mult_hilo_unit #(
  parameter int                     WORD_LEN    = 32,
  parameter int                     EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] CMD_MULT    = EXE_CMD_LEN'(10),
  parameter logic [EXE_CMD_LEN-1:0] CMD_MFHI    = EXE_CMD_LEN'(11),
  parameter logic [EXE_CMD_LEN-1:0] CMD_MFLO    = EXE_CMD_LEN'(12)
) (
  input  logic            clk,
  input  logic            rst,
  mult_hilo_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WORD_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WORD_LEN-1:0]   r_hi;
  logic [WORD_LEN-1:0]   r_lo;
  logic [WORD_LEN-1:0]   r_acc;
  logic [WORD_LEN-1:0]   r_mplier;
  logic [WORD_LEN-1:0]   r_mcand;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign;

  logic                  w_accept;
  logic                  w_stall;
  logic [WORD_LEN-1:0]   w_abs_a;
  logic [WORD_LEN-1:0]   w_abs_b;
  logic [WORD_LEN:0]     w_sum;
  logic [2*WORD_LEN-1:0] w_prod;
  logic [2*WORD_LEN-1:0] w_signed_prod;
  logic [WORD_LEN-1:0]   w_result;

  // Gated by rst so outputs read as idle while reset is held, whatever the inputs show.
  assign w_accept = rst && bus.valid && !bus.flush && (bus.exe_cmd == CMD_MULT)
                    && (r_state == S_IDLE);

  assign w_abs_a = bus.op_a[WORD_LEN-1] ? ('0 - bus.op_a) : bus.op_a;
  assign w_abs_b = bus.op_b[WORD_LEN-1] ? ('0 - bus.op_b) : bus.op_b;

  assign w_sum         = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod        = {r_acc, r_mplier};
  assign w_signed_prod = r_sign ? ('0 - w_prod) : w_prod;

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_BUSY;
          w_stall      = 1'b1;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (bus.flush)
          w_state_next = S_IDLE;
        else if (r_cnt == CNT_LAST)
          w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = '0;
    if (rst && bus.valid && (r_state == S_IDLE)) begin
      if (bus.exe_cmd == CMD_MFHI)
        w_result = r_hi;
      else if (bus.exe_cmd == CMD_MFLO)
        w_result = r_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_sign   <= bus.op_a[WORD_LEN-1] ^ bus.op_b[WORD_LEN-1];
            r_cnt    <= '0;
          end
        end
        S_BUSY: begin
          // {carry, acc, multiplier} shifted right once; product bits settle into r_mplier.
          r_acc    <= w_sum[WORD_LEN:1];
          r_mplier <= {w_sum[0], r_mplier[WORD_LEN-1:1]};
          r_cnt    <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (!bus.flush) begin
            r_hi <= w_signed_prod[2*WORD_LEN-1:WORD_LEN];
            r_lo <= w_signed_prod[WORD_LEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall  = w_stall;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.result = w_result;
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: stall length, signed products, flush, async reset, MFHI/MFLO.
module tb_mult_hilo_unit;

  localparam logic [3:0] CMD_MULT = 4'd10;
  localparam logic [3:0] CMD_MFHI = 4'd11;
  localparam logic [3:0] CMD_MFLO = 4'd12;
  localparam logic [3:0] CMD_NOP  = 4'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mult_hilo_unit_if #(.WORD_LEN(32), .EXE_CMD_LEN(4)) bus ();

  mult_hilo_unit #(
    .WORD_LEN(32), .EXE_CMD_LEN(4),
    .CMD_MULT(CMD_MULT), .CMD_MFHI(CMD_MFHI), .CMD_MFLO(CMD_MFLO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Presents a MULT, counts stalled cycles until DONE, then steps past the DONE edge.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
    int cnt;
    bit done;
    bus.valid   = 1'b1;
    bus.flush   = 1'b0;
    bus.exe_cmd = CMD_MULT;
    bus.op_a    = a;
    bus.op_b    = b;
    #1;
    cnt  = bus.stall ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      if (bus.stall) cnt++;
      else done = 1'b1;
    end
    chk({tag, " stall_cycles"}, cnt, 33);
    chk({tag, " busy_in_done"}, bus.busy, 1);
    @(posedge clk); #1;
    chk({tag, " idle_after_done"}, bus.busy, 0);
  endtask

  initial begin
    bus.valid   = 1'b1;
    bus.flush   = 1'b0;
    bus.exe_cmd = CMD_MULT;
    bus.op_a    = 32'd7;
    bus.op_b    = 32'd6;
    #12;
    chk("reset stall", bus.stall, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    chk("reset result", bus.result, 0);
    rst = 1'b1;
    bus.valid = 1'b0;
    @(posedge clk); #1;

    // 7 x 6
    do_mult(32'd7, 32'd6, "mul7x6");
    bus.valid = 1'b0;
    #1;
    chk("mul7x6 no_reaccept stall", bus.stall, 0);
    chk("mul7x6 hi", bus.hi, 32'h0000_0000);
    chk("mul7x6 lo", bus.lo, 32'h0000_002A);
    bus.valid = 1'b1; bus.exe_cmd = CMD_MFLO;
    #1;
    chk("mflo 42", bus.result, 32'd42);
    bus.exe_cmd = CMD_NOP;
    #1;
    chk("nop result", bus.result, 0);

    // -3 x 5
    do_mult(32'hFFFF_FFFD, 32'd5, "mulm3x5");
    bus.exe_cmd = CMD_MFHI;
    #1;
    chk("mulm3x5 hi", bus.hi, 32'hFFFF_FFFF);
    chk("mulm3x5 lo", bus.lo, 32'hFFFF_FFF1);
    chk("mfhi", bus.result, 32'hFFFF_FFFF);
    bus.valid = 1'b0;
    #1;
    chk("mfhi invalid", bus.result, 0);

    // Magnitude boundaries
    do_mult(32'h8000_0000, 32'h8000_0000, "mulmin");
    chk("mulmin hi", bus.hi, 32'h4000_0000);
    chk("mulmin lo", bus.lo, 32'h0000_0000);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulm1");
    chk("mulm1 hi", bus.hi, 32'h0000_0000);
    chk("mulm1 lo", bus.lo, 32'h0000_0001);

    // 3 x 4 then flushed 5 x 5
    do_mult(32'd3, 32'd4, "mul3x4");
    chk("mul3x4 lo", bus.lo, 32'd12);
    bus.op_a = 32'd5; bus.op_b = 32'd5;
    #1;
    chk("flush accept stall", bus.stall, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("flush busy c10", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    #1;
    chk("flush busy", bus.busy, 0);
    chk("flush stall", bus.stall, 0);
    chk("flush hi", bus.hi, 32'd0);
    chk("flush lo", bus.lo, 32'd12);

    // Reset in BUSY cycle 20 of 9 x 9
    bus.valid = 1'b1; bus.exe_cmd = CMD_MULT;
    bus.op_a = 32'd9; bus.op_b = 32'd9;
    repeat (20) @(posedge clk);
    #1;
    chk("rst busy c20", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("rst mid busy", bus.busy, 0);
    chk("rst mid stall", bus.stall, 0);
    chk("rst mid hi", bus.hi, 0);
    chk("rst mid lo", bus.lo, 0);
    #2;
    bus.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.exe_cmd = CMD_MFLO;
    #1;
    chk("rst mflo", bus.result, 0);
    chk("rst stays idle", bus.busy, 0);

    // Back-to-back 2 x 3 then 4 x 5
    do_mult(32'd2, 32'd3, "mul2x3");
    chk("mul2x3 lo", bus.lo, 32'd6);
    do_mult(32'd4, 32'd5, "mul4x5");
    bus.valid = 1'b0;
    #1;
    chk("mul4x5 stall", bus.stall, 0);
    chk("mul4x5 hi", bus.hi, 32'd0);
    chk("mul4x5 lo", bus.lo, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Multi-cycle signed multiplier and HI/LO register file in the EXE stage, directly downstream of the decode controller.
- Consumes the controller's EXE_CMD for MULT, MFHI and MFLO.
- Executes MULT as a radix-2 shift-add over WORD_LEN cycles and holds the pipeline through a stall output to the hazard unit.
- Serves MFHI/MFLO reads as the EXE result for the writeback path.

Parameters:
- WORD_LEN, 32, operand and HI/LO width.
- EXE_CMD_LEN, 4, width of exe_cmd.
- CMD_MULT, `EXE_MULT, exe_cmd encoding that starts a multiply.
- CMD_MFHI, `EXE_MFHI, exe_cmd encoding that reads HI.
- CMD_MFLO, `EXE_MFLO, exe_cmd encoding that reads LO.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid  input  1  a real (non-bubble) instruction is in EXE.
- flush  input  1  synchronous cancel of EXE content (branch taken).
- exe_cmd  input  EXE_CMD_LEN  command from the ID/EXE register.
- op_a  input  WORD_LEN  rs value (after forwarding).
- op_b  input  WORD_LEN  rt value (after forwarding).
- result  output  WORD_LEN  HI or LO for MFHI/MFLO, else 0.
- stall  output  1  freeze PC, IF/ID and ID/EXE.
- busy  output  1  state != IDLE.
- hi  output  WORD_LEN  architectural HI.
- lo  output  WORD_LEN  architectural LO.

Behaviour:
- Reset (rst=0, async): state IDLE; hi, lo, accumulator, counter, sign flag all cleared to 0. Outputs: stall=0, busy=0, result=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept condition: valid=1 & exe_cmd==CMD_MULT & flush=0.
  - On accept, stall=1 combinationally in that same cycle.
  - At the clock edge: load multiplicand=|op_a|, multiplier=|op_b|, upper accumulator=0, sign=op_a[MSB]^op_b[MSB], counter=0; go to BUSY.
  - |x| is the WORD_LEN-bit unsigned magnitude, so 0x80000000 gives 2^31.
- BUSY:
  - stall=1 every cycle.
  - Each cycle: if multiplier LSB=1, add multiplicand to the upper accumulator using a WORD_LEN+1-bit carry. Then shift {carry, acc, multiplier} right by 1. Increment counter.
  - When counter==WORD_LEN-1 at the edge, go to DONE. BUSY lasts exactly WORD_LEN cycles.
- DONE:
  - stall=0; the MULT retires from EXE at this edge.
  - At the edge: the 2*WORD_LEN product is two's-complement negated if sign=1, then written as {hi, lo}.
  - Next state is IDLE.
  - The MULT still present on the inputs during DONE is not re-accepted.
- Timing: total stall is WORD_LEN+1 cycles (33 by default). HI/LO become visible the cycle after DONE.
- MFHI/MFLO:
  - result=hi (or lo) combinationally when valid=1, state==IDLE and exe_cmd matches.
  - result=0 for any other command or when valid=0.
  - There is no internal HI/LO forwarding; the first instruction after DONE sees the new values.
- flush=1:
  - In BUSY or DONE: next state IDLE, hi/lo unchanged, stall deasserts the following cycle.
  - In IDLE: suppresses acceptance.
  - flush takes priority over the DONE write.
- Reset mid-operation: immediate return to IDLE with hi=lo=0; no partial write.
- Non-MULT commands while BUSY cannot arrive, because the pipeline is stalled. They are ignored.
- Width rules: the accumulator is WORD_LEN+1 bits; negation uses a full 2*WORD_LEN bits; no truncation.

Test Plan:
- Reset, then MULT op_a=7, op_b=6 → stall high for exactly 33 cycles; next cycle hi=0x00000000, lo=0x0000002A; a following MFLO gives result=42.
- MULT op_a=0xFFFFFFFD (-3), op_b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MFHI result=0xFFFFFFFF.
- MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. MULT 0xFFFFFFFF × 0xFFFFFFFF → hi=0, lo=1.
- MULT 3×4 completes; then MULT 5×5 with flush=1 asserted in BUSY cycle 10 → busy=0 next cycle; hi=0, lo=12 retained.
- rst pulled low in BUSY cycle 20 of MULT 9×9 → immediately state IDLE, stall=0, hi=lo=0; after release, MFLO returns 0.
- Back-to-back MULT 2×3 then MULT 4×5 → two separate 33-cycle stalls, no re-accept of the first in its DONE cycle; final lo=20.
